// File: rtl/usb_transmitter_if.sv
// Byte-side handshake and line-side outputs of the USB transmitter.
// The master feeds bytes in; the slave drives the serial line.
interface usb_transmitter_if;
  logic [7:0] Data_In;
  logic       Tx_Valid;
  logic       Tx_Ready;
  logic       Data_Out;
  logic       Diff;
  logic       Tx_Active;

  modport master (
    output Data_In,
    output Tx_Valid,
    input  Tx_Ready,
    input  Data_Out,
    input  Diff,
    input  Tx_Active
  );

  modport slave (
    input  Data_In,
    input  Tx_Valid,
    output Tx_Ready,
    output Data_Out,
    output Diff,
    output Tx_Active
  );
endinterface

// File: rtl/usb_transmitter.sv
// USB low-level transmitter: SYNC, NRZI data with bit stuffing, EOP.
// One line bit per clock; byte holding register allows back-to-back bytes.
module usb_tx_core (
  input  logic                 Clk,
  input  logic                 Rst,
  usb_transmitter_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } state_t;

  state_t     state_q;
  logic [7:0] hold_q;
  logic [7:0] shift_q;
  logic       hold_full_q;
  logic [2:0] bit_q;
  logic [2:0] ones_q;
  logic       pend_q;
  logic [1:0] eop_q;
  logic       dout_q;
  logic       diff_q;
  logic       act_q;
  logic       rdy_q;

  logic stuff_d;
  logic raw_d;
  logic last_d;
  logic pend_d;
  logic bnd_d;
  logic acc_d;
  logic line_d;

  always_comb begin
    stuff_d = (ones_q == 3'd6);
    raw_d   = 1'b0;
    if (!stuff_d) begin
      raw_d = (state_q == SYNC) ? (bit_q == 3'd7)
                                : shift_q[bit_q];
    end
    last_d = (bit_q == 3'd7);
    // last bit makes the 6th one: boundary waits for the stuffed 0
    pend_d = !stuff_d && last_d && raw_d &&
             (ones_q == 3'd5);
    bnd_d  = stuff_d ? pend_q : (last_d && !pend_d);
    acc_d  = bus.Tx_Valid && rdy_q;
    line_d = raw_d ? dout_q : ~dout_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      ones_q      <= '0;
      pend_q      <= 1'b0;
      eop_q       <= '0;
      dout_q      <= 1'b1;
      diff_q      <= 1'b1;
      act_q       <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          dout_q <= 1'b1;
          diff_q <= 1'b1;
          act_q  <= 1'b0;
          bit_q  <= '0;
          ones_q <= '0;
          pend_q <= 1'b0;
          if (acc_d) begin
            hold_q      <= bus.Data_In;
            hold_full_q <= 1'b1;
            rdy_q       <= 1'b0;
            state_q     <= SYNC;
          end
        end
        SYNC, DATA: begin
          dout_q <= line_d;
          diff_q <= 1'b1;
          act_q  <= 1'b1;
          pend_q <= pend_d;
          if (stuff_d) begin
            ones_q <= '0;
          end else begin
            ones_q <= raw_d ? ones_q + 3'd1 : 3'd0;
            bit_q  <= bit_q + 3'd1;
          end
          if (bnd_d) begin
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              rdy_q       <= 1'b1;
              state_q     <= DATA;
            end else if (acc_d) begin
              // byte arriving exactly at the boundary goes straight in
              shift_q <= bus.Data_In;
              state_q <= DATA;
            end else begin
              rdy_q   <= 1'b0;
              eop_q   <= '0;
              state_q <= EOP;
            end
          end else if (acc_d) begin
            hold_q      <= bus.Data_In;
            hold_full_q <= 1'b1;
            rdy_q       <= 1'b0;
          end
        end
        EOP: begin
          eop_q <= eop_q + 2'd1;
          unique case (eop_q)
            2'd0, 2'd1: begin
              dout_q <= 1'b0;
              diff_q <= 1'b0;
            end
            2'd2: begin
              dout_q <= 1'b1;
              diff_q <= 1'b1;
            end
            default: begin
              dout_q  <= 1'b1;
              diff_q  <= 1'b1;
              act_q   <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Tx_Ready  = rdy_q;
  assign bus.Data_Out  = dout_q;
  assign bus.Diff      = diff_q;
  assign bus.Tx_Active = act_q;
endmodule

module usb_transmitter (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Data_In,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic       Data_Out,
  output logic       Diff,
  output logic       Tx_Active
);
  usb_transmitter_if bus ();

  assign bus.Data_In  = Data_In;
  assign bus.Tx_Valid = Tx_Valid;
  assign Tx_Ready     = bus.Tx_Ready;
  assign Data_Out     = bus.Data_Out;
  assign Diff         = bus.Diff;
  assign Tx_Active    = bus.Tx_Active;

  usb_tx_core u_core (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );
endmodule

// File: tb/tb_usb_transmitter.sv
// Bench for usb_transmitter: packet table plus scoreboard of line symbols.
// Hand sequences cover mid-packet reset and Tx_Valid held through EOP.
module tb_usb_transmitter;
  logic Clk = 1'b0;
  logic Rst;

  usb_transmitter_if bus ();

  usb_transmitter dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Data_In   (bus.Data_In),
    .Tx_Valid  (bus.Tx_Valid),
    .Tx_Ready  (bus.Tx_Ready),
    .Data_Out  (bus.Data_Out),
    .Diff      (bus.Diff),
    .Tx_Active (bus.Tx_Active)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          dcyc;
    logic [31:0] dline;
  } vec_t;

  vec_t       tab [5];
  logic [1:0] exp_q [$];
  logic [1:0] cap [64];
  int         nvec = 0;
  int         nerr = 0;
  int         cnt = 0;
  int         rises = 0;
  logic       prev_rdy = 1'b1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // reference: NRZI line levels with stuffing, {Diff,Data_Out} per cycle
  function automatic void model_byte(input logic [7:0] b,
                                     inout logic lvl,
                                     inout int ones);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) ones++;
      else begin
        ones = 0;
        lvl  = ~lvl;
      end
      exp_q.push_back({1'b1, lvl});
      if (ones == 6) begin
        ones = 0;
        lvl  = ~lvl;
        exp_q.push_back({1'b1, lvl});
      end
    end
  endfunction

  function automatic void model_pkt(input int n,
                                    input logic [7:0] b0,
                                    input logic [7:0] b1);
    logic lvl;
    int   ones;
    lvl  = 1'b1;
    ones = 0;
    model_byte(8'h80, lvl, ones);
    model_byte(b0, lvl, ones);
    if (n > 1) model_byte(b1, lvl, ones);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
  endfunction

  always @(negedge Clk) begin
    if (bus.Tx_Active) begin
      if (cnt < 64) cap[cnt] = {bus.Diff, bus.Data_Out};
      cnt++;
      if (bus.Tx_Ready && !prev_rdy) rises++;
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_extra: got %0h, want no symbol",
                 {bus.Diff, bus.Data_Out});
      end else begin
        chk("line", {bus.Diff, bus.Data_Out}, exp_q.pop_front());
      end
    end else begin
      chk("idle", {bus.Diff, bus.Data_Out}, 2'b11);
    end
    prev_rdy = bus.Tx_Ready;
  end

  task automatic put_byte(input logic [7:0] b, output int w);
    bus.Data_In  = b;
    bus.Tx_Valid = 1'b1;
    w = 0;
    while (!bus.Tx_Ready && w < 300) begin
      tick();
      w++;
    end
    chk("accept", bus.Tx_Ready, 1);
    tick();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(cnt > 0 && !bus.Tx_Active) && t < 400) begin
      tick();
      t++;
    end
    chk("done", bus.Tx_Active, 0);
  endtask

  task automatic run_pkt(input vec_t v);
    int w;
    cnt   = 0;
    rises = 0;
    model_pkt(v.n, v.b0, v.b1);
    put_byte(v.b0, w);
    if (v.n > 1) put_byte(v.b1, w);
    bus.Tx_Valid = 1'b0;
    wait_done();
    chk("len", cnt, 11 + v.dcyc);
    for (int i = 0; i < v.dcyc; i++)
      chk("dbit", {31'd0, cap[8+i][0]}, {31'd0, v.dline[i]});
    chk("rdy_rises", rises, v.n);
    chk("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int w;
    int t;
    Rst          = 1'b1;
    bus.Tx_Valid = 1'b0;
    bus.Data_In  = 8'h00;
    tab[0] = '{1, 8'h00, 8'h00, 8,  32'h0000_0055};
    tab[1] = '{1, 8'hFF, 8'h00, 9,  32'h0000_01E0};
    tab[2] = '{1, 8'hFC, 8'h00, 9,  32'h0000_0101};
    tab[3] = '{1, 8'h3F, 8'h00, 9,  32'h0000_0160};
    tab[4] = '{2, 8'hA5, 8'h3C, 16, 32'h0000_4136};

    #2;
    chk("rst_dout", bus.Data_Out, 1);
    chk("rst_diff", bus.Diff, 1);
    chk("rst_act", bus.Tx_Active, 0);
    chk("rst_rdy", bus.Tx_Ready, 1);
    tick();
    tick();
    Rst = 1'b0;
    tick();
    tick();

    for (int k = 0; k < 5; k++) run_pkt(tab[k]);

    // reset in the middle of data bit 3
    cnt = 0;
    model_pkt(1, 8'h5A, 8'h00);
    put_byte(8'h5A, w);
    bus.Tx_Valid = 1'b0;
    t = 0;
    while (cnt < 12 && t < 100) begin
      tick();
      t++;
    end
    chk("mid_active", bus.Tx_Active, 1);
    Rst = 1'b1;
    #1;
    chk("arst_dout", bus.Data_Out, 1);
    chk("arst_diff", bus.Diff, 1);
    chk("arst_act", bus.Tx_Active, 0);
    chk("arst_rdy", bus.Tx_Ready, 1);
    exp_q.delete();
    tick();
    tick();
    Rst = 1'b0;
    repeat (5) tick();
    chk("post_rst_act", bus.Tx_Active, 0);
    run_pkt(tab[0]);

    // Tx_Valid raised during EOP
    cnt = 0;
    model_pkt(1, 8'h00, 8'h00);
    put_byte(8'h00, w);
    bus.Tx_Valid = 1'b0;
    t = 0;
    while (bus.Diff && t < 100) begin
      tick();
      t++;
    end
    chk("eop_seen", bus.Diff, 0);
    model_pkt(1, 8'hC3, 8'h00);
    put_byte(8'hC3, w);
    bus.Tx_Valid = 1'b0;
    chk("eop_wait", w, 3);
    chk("acc_act", bus.Tx_Active, 0);
    chk("acc_dout", bus.Data_Out, 1);
    cnt   = 0;
    rises = 0;
    tick();
    chk("sync_act", bus.Tx_Active, 1);
    chk("sync_dout", bus.Data_Out, 0);
    wait_done();
    chk("c3_len", cnt, 19);
    chk("c3_sb_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
